data_mem_responder: RTL and testbench

//  Data-memory side of the control unit's memread/memwrite interface: services lw/sw

---
 rtl/data_mem_responder.sv | 146 ++++++++++++++
 tb/tb_data_mem_responder.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Word-addressed data memory that services lw/sw requests with configurable wait states.
// It freezes the pipeline through stall and signals completion with one-cycle done/err pulses.
module data_mem_responder #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 6,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              memread,
    input  logic              memwrite,
    input  logic [31:0]       addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              stall,
    output logic              done,
    output logic              err
);

    localparam int         DEPTH     = 1 << ADDR_W;
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    logic [1:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              op_w_q, op_w_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              stall_s;
    logic              mem_we_s;
    logic              req_s;
    logic              illegal_s;
    logic [ADDR_W-1:0] req_idx_s;
    logic              unused_addr_s;

    logic [DATA_W-1:0] mem_q [DEPTH];

    assign req_s         = memread | memwrite;
    assign illegal_s     = (memread & memwrite) | (addr[1:0] != 2'b00);
    assign req_idx_s     = addr[ADDR_W+1:2];
    assign unused_addr_s = ^addr[31:ADDR_W+2];

    // Next-state, latch and response logic for the request FSM.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_w_d   = op_w_q;
        idx_d    = idx_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        stall_s  = 1'b0;
        mem_we_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_s && illegal_s) begin
                    err_d = 1'b1;
                end else if (req_s) begin
                    stall_s = 1'b1;
                    op_w_d  = memwrite;
                    idx_d   = req_idx_s;
                    wdata_d = wdata;
                    if (WAIT_CYCLES == 0) begin
                        // No wait states: the read data must already be in rdata during RESP.
                        state_d = ST_RESP;
                        done_d  = 1'b1;
                        if (!memwrite) begin
                            rdata_d = mem_q[req_idx_s];
                        end else begin
                            rdata_d = rdata_q;
                        end
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                stall_s = 1'b1;
                if (cnt_q <= 4'd1) begin
                    state_d = ST_RESP;
                    cnt_d   = 4'd0;
                    done_d  = 1'b1;
                    if (!op_w_q) begin
                        rdata_d = mem_q[idx_q];
                    end else begin
                        rdata_d = rdata_q;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                mem_we_s = op_w_q;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            op_w_q  <= 1'b0;
            idx_q   <= {ADDR_W{1'b0}};
            wdata_q <= {DATA_W{1'b0}};
            rdata_q <= {DATA_W{1'b0}};
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_w_q  <= op_w_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Storage array; a store commits on the RESP edge unless reset cancels it.
    always_ff @(posedge clk) begin
        if (rst_n && mem_we_s) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    assign stall = rst_n & stall_s;
    assign rdata = rdata_q;
    assign done  = done_q;
    assign err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: a timeline model checks two instances (2 and 0 wait states)
// every cycle, and directed vectors pin the model with hand-computed values.
module tb_data_mem_responder;

    logic        clk;
    logic        rstn [2];
    logic        mr   [2];
    logic        mw   [2];
    logic [31:0] ad   [2];
    logic [31:0] wd   [2];
    logic [31:0] rd   [2];
    logic        st   [2];
    logic        dn   [2];
    logic        er   [2];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    data_mem_responder #(.DATA_W(32), .ADDR_W(6), .WAIT_CYCLES(2)) dut_a (
        .clk(clk), .rst_n(rstn[0]), .memread(mr[0]), .memwrite(mw[0]), .addr(ad[0]),
        .wdata(wd[0]), .rdata(rd[0]), .stall(st[0]), .done(dn[0]), .err(er[0])
    );

    data_mem_responder #(.DATA_W(32), .ADDR_W(6), .WAIT_CYCLES(0)) dut_b (
        .clk(clk), .rst_n(rstn[1]), .memread(mr[1]), .memwrite(mw[1]), .addr(ad[1]),
        .wdata(wd[1]), .rdata(rd[1]), .stall(st[1]), .done(dn[1]), .err(er[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Model: a legal request in cycle t completes (done) in cycle t+WC+1; stores land after that.
    int          wc     [2] = '{2, 0};
    logic [31:0] mmem   [2][64];
    bit          busy   [2];
    int          resp_c [2];
    bit          m_w    [2];
    int          m_idx  [2];
    logic [31:0] m_wd   [2];
    logic [31:0] e_rd   [2];
    bit          e_dn   [2];
    bit          e_er   [2];
    bit          e_val  [2] = '{1'b0, 1'b0};

    task automatic model_step(input int i);
        bit          req;
        bit          legal;
        bit          exp_st;
        bit          nd;
        bit          ne;
        logic [31:0] nrd;
        req   = mr[i] | mw[i];
        legal = req && !(mr[i] && mw[i]) && ((ad[i] % 32'd4) == 32'd0);
        if (!rstn[i])     exp_st = 1'b0;
        else if (busy[i]) exp_st = (cyc < resp_c[i]);
        else              exp_st = legal;
        if (e_val[i]) begin
            chk($sformatf("stall[%0d]", i), {31'd0, st[i]}, {31'd0, exp_st});
            chk($sformatf("done[%0d]", i), {31'd0, dn[i]}, {31'd0, e_dn[i]});
            chk($sformatf("err[%0d]", i), {31'd0, er[i]}, {31'd0, e_er[i]});
            chk($sformatf("rdata[%0d]", i), rd[i], e_rd[i]);
            chk($sformatf("err_done_excl[%0d]", i), {31'd0, dn[i] & er[i]}, 32'd0);
        end
        nd  = 1'b0;
        ne  = 1'b0;
        nrd = e_rd[i];
        if (!rstn[i]) begin
            busy[i]  = 1'b0;
            nrd      = 32'd0;
            e_val[i] = 1'b1;
        end else begin
            if (busy[i] && cyc == resp_c[i]) begin
                if (m_w[i]) mmem[i][m_idx[i]] = m_wd[i];
                busy[i] = 1'b0;
            end else if (!busy[i] && req) begin
                if (!legal) begin
                    ne = 1'b1;
                end else begin
                    busy[i]   = 1'b1;
                    resp_c[i] = cyc + wc[i] + 1;
                    m_w[i]    = mw[i];
                    m_idx[i]  = int'((ad[i] / 32'd4) % 32'd64);
                    m_wd[i]   = wd[i];
                end
            end
            if (busy[i] && cyc + 1 == resp_c[i]) begin
                nd = 1'b1;
                if (!m_w[i]) nrd = mmem[i][m_idx[i]];
            end
        end
        e_dn[i] = nd;
        e_er[i] = ne;
        e_rd[i] = nrd;
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) model_step(i);
        cyc++;
    end

    // Issues one request for a single cycle and observes a fixed 6-cycle window.
    task automatic req(input int i, input bit r, input bit w, input logic [31:0] a,
                       input logic [31:0] d, output int n_stall, output int done_at,
                       output int err_at, output logic [31:0] got);
        mr[i] = r; mw[i] = w; ad[i] = a; wd[i] = d;
        n_stall = 0; done_at = -1; err_at = -1; got = 32'd0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (st[i]) n_stall++;
            if (dn[i]) begin done_at = k; got = rd[i]; end
            if (er[i]) err_at = k;
            @(posedge clk); #1;
            if (k == 0) begin mr[i] = 1'b0; mw[i] = 1'b0; end
        end
    endtask

    int          ns, da, ea;
    logic [31:0] g;
    logic [31:0] bb_a [4] = '{32'h0000_000C, 32'h0000_0040, 32'h0000_00FC, 32'h0000_0080};
    logic [31:0] bb_d [4] = '{32'h1111_0000, 32'h2222_0001, 32'h3333_0002, 32'h4444_0003};

    initial begin
        for (int i = 0; i < 2; i++) begin
            rstn[i] = 1'b0; mr[i] = 1'b0; mw[i] = 1'b0; ad[i] = 32'd0; wd[i] = 32'd0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_rdata", rd[0], 32'd0);
        chk("reset_stall", {31'd0, st[0]}, 32'd0);
        chk("reset_done", {31'd0, dn[0]}, 32'd0);
        chk("reset_err", {31'd0, er[0]}, 32'd0);
        @(posedge clk); #1;
        rstn[0] = 1'b1; rstn[1] = 1'b1;

        // Two wait states: store then load at 0x10.
        req(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, ns, da, ea, g);
        chk("sw_stall_cycles", ns, 32'd3);
        chk("sw_done_cycle", da, 32'd3);
        req(0, 1'b1, 1'b0, 32'h10, 32'd0, ns, da, ea, g);
        chk("lw_done_cycle", da, 32'd3);
        chk("lw_data", g, 32'hDEADBEEF);

        // 0x100 wraps onto word 0 of a 64-word memory.
        req(0, 1'b0, 1'b1, 32'h100, 32'h1234, ns, da, ea, g);
        req(0, 1'b1, 1'b0, 32'h0, 32'd0, ns, da, ea, g);
        chk("wrap_data", g, 32'h1234);

        req(0, 1'b1, 1'b0, 32'h6, 32'd0, ns, da, ea, g);
        chk("misalign_err_cycle", ea, 32'd1);
        chk("misalign_stall", ns, 32'd0);
        chk("misalign_no_done", da, -32'sd1);
        req(0, 1'b1, 1'b1, 32'h10, 32'h0BAD_0BAD, ns, da, ea, g);
        chk("rdwr_err_cycle", ea, 32'd1);
        chk("rdwr_no_done", da, -32'sd1);
        req(0, 1'b1, 1'b0, 32'h10, 32'd0, ns, da, ea, g);
        chk("rdwr_mem_unchanged", g, 32'hDEADBEEF);

        // Reset during WAIT cancels the pending store.
        req(0, 1'b0, 1'b1, 32'h20, 32'h55, ns, da, ea, g);
        mw[0] = 1'b1; ad[0] = 32'h20; wd[0] = 32'hAA;
        @(posedge clk); #1;
        mw[0] = 1'b0; rstn[0] = 1'b0;
        @(negedge clk);
        chk("abort_stall_in_reset", {31'd0, st[0]}, 32'd0);
        @(posedge clk); #1;
        rstn[0] = 1'b1;
        req(0, 1'b1, 1'b0, 32'h20, 32'd0, ns, da, ea, g);
        chk("abort_old_data", g, 32'h55);

        // Zero wait states.
        req(1, 1'b0, 1'b1, 32'h0C, 32'hA5A5_0001, ns, da, ea, g);
        chk("wc0_sw_done_cycle", da, 32'd1);
        chk("wc0_sw_stall", ns, 32'd1);
        req(1, 1'b1, 1'b0, 32'h0C, 32'd0, ns, da, ea, g);
        chk("wc0_lw_done_cycle", da, 32'd1);
        chk("wc0_lw_data", g, 32'hA5A5_0001);

        // Back-to-back sw/lw pairs, each request issued in the first IDLE cycle.
        for (int j = 0; j < 4; j++) begin
            mw[1] = 1'b1; ad[1] = bb_a[j]; wd[1] = bb_d[j];
            @(posedge clk); #1;
            mw[1] = 1'b0;
            @(negedge clk);
            chk($sformatf("b2b_sw_done%0d", j), {31'd0, dn[1]}, 32'd1);
            @(posedge clk); #1;
            mr[1] = 1'b1; ad[1] = bb_a[j];
            @(posedge clk); #1;
            mr[1] = 1'b0;
            @(negedge clk);
            chk($sformatf("b2b_lw_done%0d", j), {31'd0, dn[1]}, 32'd1);
            chk($sformatf("b2b_lw_data%0d", j), rd[1], bb_d[j]);
            @(posedge clk); #1;
        end

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
